// File: rtl/dmem_be_unit_if.sv
// Request/IO bus bundle between the MEM stage, the data-memory block and the IO bridge.
// Latency: n/a (wires only); rdata lands one cycle after the request it answers.
// Backpressure: none; a request is presented every cycle.
// Optional: DMEM_ALIGN_CHECK_EN adds the misalign flag.
// Ports: req_* (request from EX), io_* (IO bridge side), be/hit_dm/rdata (results).
interface dmem_be_unit_if;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_we;
  logic        req_byte;
  logic        req_half;
  logic [31:0] io_rdata;
  logic [29:0] io_addr;
  logic [31:0] io_wdata;
  logic [3:0]  io_be;
  logic        io_we;
  logic [3:0]  be;
  logic        hit_dm;
  logic [31:0] rdata;
`ifdef DMEM_ALIGN_CHECK_EN
  logic        misalign;
`endif

  // Pipeline / bridge side: drives the request, supplies IO read data.
  modport master (
    output req_addr, req_wdata, req_we, req_byte, req_half, io_rdata,
    input  io_addr, io_wdata, io_be, io_we, be, hit_dm, rdata
`ifdef DMEM_ALIGN_CHECK_EN
    , input misalign
`endif
  );

  // Data-memory block side.
  modport slave (
    input  req_addr, req_wdata, req_we, req_byte, req_half, io_rdata,
    output io_addr, io_wdata, io_be, io_we, be, hit_dm, rdata
`ifdef DMEM_ALIGN_CHECK_EN
    , output misalign
`endif
  );
endinterface

// File: rtl/dmem_be_unit.sv
// MEM-stage data memory: byte enables, RAM/IO region decode, 2**ADDR_W x 32 RAM.
// Latency: be/hit_dm/io_* combinational; rdata one cycle after the request.
// Backpressure: none; a new request is accepted every cycle.
// Optional: DMEM_ALIGN_CHECK_EN adds misalign and blocks misaligned stores.
// Ports: clk, rst (sync, active high), bus (dmem_be_unit_if.slave).
module dmem_be_unit #(
  parameter int          ADDR_W    = 12,
  parameter logic [15:0] DM_LIMIT  = 16'h3000,
  parameter string       INIT_FILE = ""
) (
  input  logic           clk,
  input  logic           rst,
  dmem_be_unit_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0]       mem [0:DEPTH-1];
  logic [ADDR_W-1:0] idx;
  logic [3:0]        be;
  logic              hit_dm;
  logic              wr_ok;
  logic              dm_we;
  logic [31:0]       ram_q;
  logic              sel_dm_q;

  // Byte enables; byte size wins over half size when both are set.
  always_comb begin
    be = 4'b1111;
    if (bus.req_byte) begin
      be = 4'b0001 << bus.req_addr[1:0];
    end else if (bus.req_half) begin
      be = bus.req_addr[1] ? 4'b1100 : 4'b0011;
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  logic misalign;
  always_comb begin
    misalign = 1'b0;
    if (!bus.req_byte) begin
      if (bus.req_half) misalign = bus.req_addr[0];
      else              misalign = (bus.req_addr[1:0] != 2'b00);
    end
  end
  assign wr_ok        = ~misalign;
  assign bus.misalign = misalign;
`else
  assign wr_ok = 1'b1;
`endif

  // Only the low 16 address bits take part in the region decode.
  assign hit_dm = (bus.req_addr[15:0] < DM_LIMIT);
  assign idx    = bus.req_addr[ADDR_W+1:2];
  assign dm_we  = bus.req_we & hit_dm & wr_ok & ~rst;

  assign bus.be       = be;
  assign bus.hit_dm   = hit_dm;
  assign bus.io_addr  = bus.req_addr[31:2];
  assign bus.io_wdata = bus.req_wdata;
  assign bus.io_be    = be;
  assign bus.io_we    = bus.req_we & ~hit_dm & wr_ok & ~rst;

  // RAM array has no reset; contents survive rst.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (dm_we && be[i]) begin
        mem[idx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
      end
    end
  end

  // Read-first output register: it samples the array before this edge's write
  // lands, so a same-cycle store/load returns the old word. Held when the
  // request targets IO so the array stays idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_q    <= '0;
      sel_dm_q <= 1'b1;
    end else begin
      sel_dm_q <= hit_dm;
      if (hit_dm) begin
        ram_q <= mem[idx];
      end
    end
  end

  // IO read data is combinational from the bridge in the cycle after the request.
  assign bus.rdata = sel_dm_q ? ram_q : bus.io_rdata;

endmodule

// File: tb/tb_dmem_be_unit.sv
module tb_dmem_be_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dmem_be_unit_if bus ();

  dmem_be_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference memory: one entry per byte address that has been written.
  logic [7:0] mm [int];

  // What the previous request should return on rdata this cycle.
  logic        prev_known = 1'b0;
  logic        prev_io    = 1'b0;
  logic [31:0] prev_exp   = '0;

  // Values captured in the most recent step.
  logic [31:0] obs_rdata;
  logic [3:0]  obs_be;
  logic        obs_hit;
  logic        obs_iowe;
  logic [29:0] obs_ioaddr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One request cycle: drive after the falling edge, check just after, then
  // advance the model as the next rising edge would.
  task automatic step(input logic r, input logic [31:0] a, input logic [31:0] wd,
                      input logic we, input logic b, input logic h, input logic [31:0] ior);
    int          n;
    int          lo;
    int          base;
    logic [3:0]  exp_be;
    logic        exp_hit;
    logic        mis;
    logic        all_known;
    logic [31:0] word;

    @(negedge clk);
    rst           = r;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    bus.req_we    = we;
    bus.req_byte  = b;
    bus.req_half  = h;
    bus.io_rdata  = ior;
    #1;

    if (prev_io)         chk("rdata_io", bus.rdata, ior);
    else if (prev_known) chk("rdata_dm", bus.rdata, prev_exp);

    // An access of n bytes starting at lane lo, lanes aligned to the access size.
    n       = b ? 1 : (h ? 2 : 4);
    lo      = b ? int'(a[1:0]) : (h ? (a[1] ? 2 : 0) : 0);
    exp_be  = 4'(((1 << n) - 1) << lo);
    exp_hit = (int'(a[15:0]) < 'h3000);
    mis     = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
    mis = (!b && h && a[0]) || (!b && !h && (a[1:0] != 2'b00));
    chk("misalign", bus.misalign, mis);
`endif

    chk("be",       bus.be,       exp_be);
    chk("io_be",    bus.io_be,    exp_be);
    chk("hit_dm",   bus.hit_dm,   exp_hit);
    chk("io_we",    bus.io_we,    we && !exp_hit && !r && !mis);
    chk("io_addr",  bus.io_addr,  a >> 2);
    chk("io_wdata", bus.io_wdata, wd);

    obs_rdata  = bus.rdata;
    obs_be     = bus.be;
    obs_hit    = bus.hit_dm;
    obs_iowe   = bus.io_we;
    obs_ioaddr = bus.io_addr;

    if (r) begin
      prev_known = 1'b1;
      prev_io    = 1'b0;
      prev_exp   = '0;
    end else if (exp_hit) begin
      base      = int'(a[13:2]) * 4;
      all_known = 1'b1;
      word      = '0;
      for (int l = 0; l < 4; l++) begin
        if (mm.exists(base + l)) word[8*l +: 8] = mm[base + l];
        else                     all_known = 1'b0;
      end
      prev_known = all_known;
      prev_io    = 1'b0;
      prev_exp   = word;
      if (we && !mis) begin
        for (int l = 0; l < 4; l++) begin
          if (exp_be[l]) mm[base + l] = wd[8*l +: 8];
        end
      end
    end else begin
      prev_known = 1'b0;
      prev_io    = 1'b1;
    end
  endtask

  task automatic nop();
    step(1'b0, 32'h0000_0100, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] rnd;
    int          kind;
    int          sz;

    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_we    = 1'b0;
    bus.req_byte  = 1'b0;
    bus.req_half  = 1'b0;
    bus.io_rdata  = '0;

    // Reset, then the register must read zero.
    step(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    nop();
    chk("rst_rdata0", obs_rdata, 32'h0);

    // Byte-enable sweep.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 32'h100 + 32'(i), 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
      chk("be_byte", 32'(obs_be), 32'(1 << i));
    end
    step(1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0);
    chk("be_half0", 32'(obs_be), 32'h3);
    step(1'b0, 32'h102, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0);
    chk("be_half2", 32'(obs_be), 32'hC);
    step(1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("be_word", 32'(obs_be), 32'hF);
    step(1'b0, 32'h102, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0);
    chk("be_bytewins", 32'(obs_be), 32'h4);

    // Word store then load.
    step(1'b0, 32'h10, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("ws_hit", 32'(obs_hit), 32'h1);
    nop();
    chk("ws_rdata", obs_rdata, 32'hDEADBEEF);

    // Partial stores merge into the word.
    step(1'b0, 32'h11, 32'h0000_5500, 1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b0, 32'h12, 32'hAAAA_0000, 1'b1, 1'b0, 1'b1, 32'h0);
    step(1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    nop();
    chk("partial_rdata", obs_rdata, 32'hAAAA55EF);

    // Region boundary.
    step(1'b0, 32'h2FFC, 32'h0123_4567, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("bnd_dm_iowe", 32'(obs_iowe), 32'h0);
    step(1'b0, 32'h3000, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("bnd_io_iowe", 32'(obs_iowe), 32'h1);
    chk("bnd_io_addr", 32'(obs_ioaddr), 32'hC00);
    step(1'b0, 32'h2FFC, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    nop();
    chk("bnd_dm_rdata", obs_rdata, 32'h0123_4567);
    step(1'b0, 32'h7F00, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 1'b0, 32'h1234_5678);
    chk("io_rdata", obs_rdata, 32'h1234_5678);

    // Upper address bits are ignored.
    step(1'b0, 32'hFFFF_0020, 32'h1111_1111, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    nop();
    chk("upper_rdata", obs_rdata, 32'h1111_1111);

    // Store blocked during reset; contents survive.
    step(1'b0, 32'h40, 32'h0BAD_C0DE, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'h40, 32'h9999_9999, 1'b1, 1'b0, 1'b0, 32'h0);
    nop();
    chk("rst_rdata", obs_rdata, 32'h0);
    step(1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    nop();
    chk("rst_keep", obs_rdata, 32'h0BAD_C0DE);

    // Seed a small RAM window so random loads have known contents.
    for (int i = 0; i < 64; i++) begin
      rnd = $urandom;
      step(1'b0, 32'(i * 4), rnd, 1'b1, 1'b0, 1'b0, $urandom);
    end

    // Random traffic against the reference model.
    for (int i = 0; i < 1500; i++) begin
      kind = $urandom_range(0, 39);
      rnd  = $urandom;
      if (kind < 8) a = {rnd[31:16], 16'($urandom_range(16'h3000, 16'hFFFF))};
      else          a = {rnd[31:16], 16'($urandom_range(0, 255))};
      sz = $urandom_range(0, 3);
      step(kind == 0, a, $urandom, 1'($urandom_range(0, 1)),
           sz == 0 || sz == 3, sz == 1 || sz == 3, $urandom);
    end
    nop();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
